// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// Carries ovf only when SERIAL_ADD_SUB_OVF_EN is defined.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, result, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, result, cout, ovf);
`else
  modport master (output start, sub, a, b, input busy, done, result, cout);
  modport slave  (input start, sub, a, b, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor, one bit per clock, LSB first.
// Define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_add_sub_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a, op_b, res_q;
  logic [CW-1:0]    cnt;
  logic             carry, sub_q, cout_q;
  logic             sum_bit, carry_next, last, accept;

  assign last       = (cnt == CW'(WIDTH - 1));
  assign accept     = bus.start && (state_q == IDLE || state_q == DONE);
  assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
  assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // DONE behaves like IDLE for a new request, so back-to-back starts lose no cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, with the +1 supplied as the initial carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      sub_q <= bus.sub;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res_q <= {sum_bit, res_q[WIDTH-1:1]};
      carry <= carry_next;
      cnt   <= cnt + 1'b1;
      if (last) cout_q <= sub_q ? ~carry_next : carry_next;
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q;

  // In the MSB slice the registered carry is the carry into that slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           ovf_q <= 1'b0;
    else if (state_q == RUN && last)   ovf_q <= carry ^ carry_next;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed literal cases plus a
// randomized run compared every cycle against a plain-arithmetic model.
module tb_serial_add_sub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input logic st);
    bus.a     = av;
    bus.b     = bv;
    bus.sub   = sv;
    bus.start = st;
  endtask

  // Expected {ovf, cout, result} straight from the arithmetic definition
  function automatic logic [W+1:0] expectOf(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    logic [W:0] full;
    logic       c, o;
    if (sv) begin
      full = {1'b0, av} - {1'b0, bv};
      c    = (av < bv);
      o    = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
    end else begin
      full = {1'b0, av} + {1'b0, bv};
      c    = full[W];
      o    = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    end
    return {o, c, full[W-1:0]};
  endfunction

  // Model: an accepted request occupies W busy cycles, then one done cycle
  int             remain = 0;
  logic           m_done = 1'b0;
  logic [W+1:0]   pend_vec = '0;
  logic [W+1:0]   exp_vec = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remain  <= 0;
      m_done  <= 1'b0;
      exp_vec <= '0;
    end else if (remain > 0) begin
      remain <= remain - 1;
      m_done <= (remain == 1);
      if (remain == 1) exp_vec <= pend_vec;
    end else begin
      m_done <= 1'b0;
      if (bus.start) begin
        remain   <= W;
        pend_vec <= expectOf(bus.a, bus.b, bus.sub);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", 32'(bus.busy), 32'(remain > 0));
      checkOutput("done", 32'(bus.done), 32'(m_done));
      if (remain == 0) begin
        checkOutput("result", 32'(bus.result), 32'(exp_vec[W-1:0]));
        checkOutput("cout", 32'(bus.cout), 32'(exp_vec[W]));
`ifdef SERIAL_ADD_SUB_OVF_EN
        checkOutput("ovf", 32'(bus.ovf), 32'(exp_vec[W+1]));
`endif
      end
    end
  end

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int i = 0; i < 4 * W && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic runOp(input string name, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input logic [W-1:0] er, input logic ec);
    int busyCycles = 0;
    int lat = 0;
    @(negedge clk);
    applyStimulus(av, bv, sv, 1'b1);
    for (int i = 1; i <= 4 * W && lat == 0; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busyCycles++;
      if (bus.done) lat = i;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(W + 1));
    checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'(W));
    checkOutput({name, "_result"}, 32'(bus.result), 32'(er));
    checkOutput({name, "_cout"}, 32'(bus.cout), 32'(ec));
  endtask

  initial begin
    int doneCount;
    int lat;
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_result", 32'(bus.result), 32'd0);
    checkOutput("reset_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;

    runOp("add_5_3", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    runOp("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_SUB_OVF_EN
    checkOutput("add_wrap_ovf", 32'(bus.ovf), 32'd0);
`endif
    runOp("add_7f_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADD_SUB_OVF_EN
    checkOutput("add_7f_1_ovf", 32'(bus.ovf), 32'd1);
`endif
    runOp("sub_5_3", 8'h05, 8'h03, 1'b1, 8'h02, 1'b0);
    runOp("sub_3_5", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1);

    // A request raised mid-run must be dropped entirely
    @(negedge clk);
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(8'hAA, 8'h11, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (bus.done) begin
        doneCount++;
        checkOutput("ignore_result", 32'(bus.result), 32'h08);
      end
    end
    checkOutput("ignore_done_count", 32'(doneCount), 32'd1);

    // Start held high through DONE launches the next operation at once
    @(negedge clk);
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
    waitDone("b2b_first");
    checkOutput("b2b_first_result", 32'(bus.result), 32'h08);
    lat = 0;
    for (int i = 1; i <= 4 * W && lat == 0; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) lat = i;
    end
    checkOutput("b2b_latency", 32'(lat), 32'(W + 1));
    checkOutput("b2b_second_result", 32'(bus.result), 32'h11);

    // Asynchronous reset between edges aborts the run immediately
    @(negedge clk);
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_result", 32'(bus.result), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runOp("post_reset_sub", 8'h20, 8'h01, 1'b1, 8'h1F, 1'b0);

    // Random operations with input noise while busy; the model checks each cycle
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      for (int i = 0; i < 4 * W; i++) begin
        @(negedge clk);
        if (bus.done) begin
          bus.start = 1'b0;
          break;
        end
        applyStimulus(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      end
      bus.start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Bit-serial two's-complement adder/subtractor.
- Loads two WIDTH-bit operands on a start pulse, then processes one bit per clock, LSB first, through a single full-adder slice with a registered carry/borrow.
- Signals completion with a one-cycle done pulse.
- Low-area sequential companion to the combinational full adder: same add function, plus the inverse (subtract) direction, resolved over time.

Parameters:
- WIDTH, 8, operand/result width in bits (min 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; latched with operands on accepted start.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  sum/difference; holds until next accepted start.
- cout  output  1  add: carry out of MSB; sub: borrow (1 when a<b unsigned).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE; busy=0, done=0, result=0, cout=0; internal shift registers, bit counter and carry FF all 0.
- Reset mid-operation aborts immediately: no done pulse, all outputs return to reset values.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 -> RUN, busy=1.
  - Latches opA=a.
  - opB = b (add) or ~b (sub).
  - carry FF = sub (the +1 of two's-complement negation).
  - Bit counter = 0.
  - start=0 -> stay IDLE.
- RUN, each edge:
  - s = opA[0] ^ opB[0] ^ c.
  - c' = majority(opA[0], opB[0], c).
  - opA and opB shift right by 1.
  - s shifts into result from the MSB side (result register shifts right).
  - Counter increments.
  - At the edge processing bit WIDTH-1, go to DONE.
- Entering DONE:
  - busy=0, done=1.
  - result holds the full WIDTH-bit value.
  - cout = c' (add) or ~c' (sub).
- DONE is one cycle:
  - start=1 -> accepted exactly as in IDLE (back-to-back operation); done still pulses for exactly one cycle.
  - Otherwise -> IDLE, done=0.
- Latency: start accepted at E0; RUN spans WIDTH edges (E1..E_WIDTH); done high in the cycle after E_WIDTH. Start-to-done = WIDTH+1 edges. busy is high for exactly WIDTH cycles.
- Arithmetic is modulo 2^WIDTH; no saturation.
- result is internal scratch while busy (partial value visible) and valid only from done onward. It is held stable in IDLE.
- start while busy (RUN) is ignored; a, b and sub changes during RUN have no effect.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: SERIAL_ADD_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf = carry into MSB slice XOR carry out of MSB slice, captured at the bit WIDTH-1 edge.
  - Flags signed two's-complement overflow for both add and sub.
  - Valid with done; held with result.
- Undefined: ovf port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Add, WIDTH=8: sub=0, a=0x05, b=0x03, start 1 cycle -> busy high 8 cycles; done pulses 9 edges after start; result=0x08; cout=0.
- Add wrap: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1; with SERIAL_ADD_SUB_OVF_EN, ovf=0. Also a=0x7F, b=0x01 -> result=0x80, ovf=1.
- Subtract: sub=1, a=0x05, b=0x03 -> result=0x02, cout=0. Then a=0x03, b=0x05 -> result=0xFE, cout=1 (borrow).
- Start ignored while busy: second start with a=0xAA, b=0x11 asserted 3 cycles into RUN of 0x05+0x03 -> only one done; result=0x08; no second operation.
- Back-to-back: start held high through DONE with a=0x10, b=0x01 -> first done (0x08), next operation accepted in the DONE cycle; second done exactly 9 edges later with result=0x11.
- Reset mid-op: rst asserted asynchronously (between edges) 4 cycles into RUN -> busy, done, result and cout drop to 0 immediately; no done pulse; a new start after release gives correct results.
